// File: rtl/syzygy_dac_wave_buffer.sv
// Ping-pong waveform memory for the I-channel memory-driven DDS: host fills the shadow bank, the
// swap happens at the DDS wrap to word 0. Optional forced swap: SYZYGY_DAC_WAVE_BUFFER_FORCE_SWAP_EN.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | no swap requested; host writes land in the shadow bank
//  PENDING  | commit accepted; waiting for DDS index 0 (host writes dropped)
module syzygy_dac_wave_buffer #(
   parameter int MEM_SIZE_BITS = 12,
   parameter int SWAP_TIMEOUT  = 65535
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [MEM_SIZE_BITS-1:0] host_addr,
   input  logic [31:0]              host_wdata,
   input  logic                     host_we,
   output logic [31:0]              host_rdata,
   input  logic                     host_commit,
   input  logic                     host_clear_err,
   output logic                     swap_pending,
   output logic                     overrun,
   output logic                     active_bank,
   output logic [15:0]              swap_count,
   input  logic [31:0]              dds_addr,
   output logic [31:0]              dds_data
);

   localparam int DEPTH = 1 << MEM_SIZE_BITS;

   typedef enum logic {IDLE, PENDING} state_t;

   state_t                   state;
   logic [31:0]              mem [0:2*DEPTH-1];
   logic [MEM_SIZE_BITS-1:0] dds_idx;
   logic                     dds_zero;
   logic                     force_swap;
   logic                     swap_now;
   logic                     dds_bank;
   logic                     host_bank;
   logic                     write_ok;
   logic                     drop_write;
   logic                     unused_addr_bits;

   assign dds_idx          = dds_addr[MEM_SIZE_BITS-1:0];
   assign unused_addr_bits = ^dds_addr[31:MEM_SIZE_BITS];
   assign dds_zero         = (dds_idx == '0);

   // The swap cycle already reads from the new bank so word 0 is never taken from the old one.
   assign swap_now   = (state == PENDING) && (dds_zero || force_swap);
   assign dds_bank   = active_bank ^ swap_now;
   assign host_bank  = ~active_bank;
   assign write_ok   = host_we && (state == IDLE);
   assign drop_write = host_we && (state == PENDING);

`ifdef SYZYGY_DAC_WAVE_BUFFER_FORCE_SWAP_EN
   logic [15:0] wait_cnt;
   logic [15:0] wait_next;

   assign wait_next  = wait_cnt + 16'd1;
   assign force_swap = (state == PENDING) && (wait_next == 16'(SWAP_TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_next;
      end
   end
`else
   logic unused_timeout;

   assign force_swap     = 1'b0;
   assign unused_timeout = ^16'(SWAP_TIMEOUT);
`endif

   always_ff @(posedge clk) begin
      if (write_ok) begin
         mem[{host_bank, host_addr}] <= host_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dds_data   <= '0;
         host_rdata <= '0;
      end else begin
         dds_data   <= mem[{dds_bank, dds_idx}];
         host_rdata <= write_ok ? host_wdata : mem[{host_bank, host_addr}];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         swap_pending <= 1'b0;
         active_bank  <= 1'b0;
         swap_count   <= '0;
         overrun      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (host_commit) begin
                  state        <= PENDING;
                  swap_pending <= 1'b1;
               end
            end
            PENDING: begin
               if (swap_now) begin
                  state        <= IDLE;
                  swap_pending <= 1'b0;
                  active_bank  <= ~active_bank;
                  swap_count   <= swap_count + 16'd1;
               end
            end
            default: begin
               state        <= IDLE;
               swap_pending <= 1'b0;
            end
         endcase

         if (drop_write) begin
            overrun <= 1'b1;
         end else if (host_clear_err) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule
